// File: rtl/iitk_mini_mips.sv
// Single-cycle MIPS32 subset with an IMEM loader port; one instruction retires per clk, no backpressure (init_mode stalls).
// Optional: define IITK_MIPS_DEBUG_RESULT_EN to drive debug_result with the current ALU result.

module iitk_mini_mips_dmem #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] memory [WORDS];

  assign rdata = memory[addr];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

endmodule

module iitk_mini_mips #(
  parameter int IMEM_WORDS = 4096,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_mode,
  input  logic        write_enable,
  input  logic [11:0] init_address,
  input  logic [31:0] init_instruction,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] debug_result
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] rf [32];

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] instr;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] simm;
  logic [25:0] target;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu;
  logic [31:0] wr_data;
  logic [4:0]  wr_reg;
  logic        reg_we;
  logic        mem_we;
  logic        mem_to_reg;

  logic [IW-1:0] load_addr;
  logic          dmem_we;
  logic [31:0]   dmem_rdata;

  // Fetch
  assign instr           = imem[pc[IW+1:2]];
  assign pc_out          = pc;
  assign instruction_out = instr;

  // Decode
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign simm   = {{16{instr[15]}}, instr[15:0]};
  assign target = instr[25:0];

  // $0 is hardwired to zero on the read side as well as dropped on write
  assign rs_val = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : rf[rt];

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {simm[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], target, 2'b00};

  always_comb begin
    alu        = 32'h0;
    reg_we     = 1'b0;
    wr_reg     = 5'd0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    next_pc    = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        wr_reg = rd;
        case (funct)
          F_ADD: begin alu = rs_val + rt_val; reg_we = 1'b1; end
          F_SUB: begin alu = rs_val - rt_val; reg_we = 1'b1; end
          F_AND: begin alu = rs_val & rt_val; reg_we = 1'b1; end
          F_OR:  begin alu = rs_val | rt_val; reg_we = 1'b1; end
          F_SLT: begin
            alu    = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
            reg_we = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        alu    = rs_val + simm;
        reg_we = 1'b1;
        wr_reg = rt;
      end
      OP_LW: begin
        alu        = rs_val + simm;
        reg_we     = 1'b1;
        wr_reg     = rt;
        mem_to_reg = 1'b1;
      end
      OP_SW: begin
        alu    = rs_val + simm;
        mem_we = 1'b1;
      end
      OP_BEQ: if (rs_val == rt_val) next_pc = branch_target;
      OP_BNE: if (rs_val != rt_val) next_pc = branch_target;
      OP_J:   next_pc = jump_target;
      default: ;
    endcase
  end

  assign wr_data = mem_to_reg ? dmem_rdata : alu;

  // Reset branch first so an undriven init_mode cannot matter during reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 32'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (!init_mode) begin
      pc <= next_pc;
      if (reg_we && (wr_reg != 5'd0)) rf[wr_reg] <= wr_data;
    end
  end

  // IMEM is never cleared; it only changes through the loader port
  assign load_addr = IW'(init_address);

  always_ff @(posedge clk) begin
    if (!reset && init_mode && write_enable) imem[load_addr] <= init_instruction;
  end

  assign dmem_we = mem_we && !init_mode && !reset;

  iitk_mini_mips_dmem #(
    .WORDS (DMEM_WORDS),
    .AW    (DW)
  ) DMEM (
    .clk   (clk),
    .we    (dmem_we),
    .addr  (alu[DW+1:2]),
    .wdata (rt_val),
    .rdata (dmem_rdata)
  );

`ifdef IITK_MIPS_DEBUG_RESULT_EN
  assign debug_result = alu;
`else
  assign debug_result = 32'h0;
`endif

  // Shift amount and address bits outside the word index are intentionally ignored
  logic unused_bits;
  assign unused_bits = ^{instr[10:6], alu[1:0], alu[31:DW+2], init_address};

endmodule

// File: tb/tb_iitk_mini_mips.sv
// Self-checking bench for iitk_mini_mips: directed vectors, multi-cycle sequences and random programs vs an ISA-level model.
module tb_iitk_mini_mips;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_mode = 1'b0;
  logic        write_enable = 1'b0;
  logic [11:0] init_address = 12'h0;
  logic [31:0] init_instruction = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [31:0] debug_result;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] prog [$];

  always #5 clk = ~clk;

  iitk_mini_mips dut (
    .clk              (clk),
    .reset            (reset),
    .init_mode        (init_mode),
    .write_enable     (write_enable),
    .init_address     (init_address),
    .init_instruction (init_instruction),
    .pc_out           (pc_out),
    .instruction_out  (instruction_out),
    .debug_result     (debug_result)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset the core, load prog[] through the loader port, then release so PC 0 executes next
  task automatic start_prog();
    reset = 1'b1;
    init_mode = 1'bx;
    write_enable = 1'b0;
    tick(1);
    reset = 1'b0;
    init_mode = 1'b1;
    write_enable = 1'b1;
    for (int i = 0; i < prog.size(); i++) begin
      init_address = 12'(i);
      init_instruction = prog[i];
      tick(1);
    end
    write_enable = 1'b0;
    init_mode = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] op3;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  logic [31:0] lw_words [5];
  logic [31:0] mr [8];
  logic [31:0] mm [16];
  int          kind, s, t, d, w;
  logic [15:0] imm;
  logic [31:0] simm;

  initial begin
    vecs[0]  = '{"add",        enc_r(6'h20, 5'd1, 5'd2, 5'd3), 16'd5,     16'd7,     32'h0000_000C};
    vecs[1]  = '{"sub",        enc_r(6'h22, 5'd1, 5'd2, 5'd3), 16'd5,     16'd7,     32'hFFFF_FFFE};
    vecs[2]  = '{"sub_neg",    enc_r(6'h22, 5'd1, 5'd2, 5'd3), 16'hFFFF,  16'd7,     32'hFFFF_FFF8};
    vecs[3]  = '{"and",        enc_r(6'h24, 5'd1, 5'd2, 5'd3), 16'h0F0F,  16'h00FF,  32'h0000_000F};
    vecs[4]  = '{"or",         enc_r(6'h25, 5'd1, 5'd2, 5'd3), 16'h0F0F,  16'h00FF,  32'h0000_0FFF};
    vecs[5]  = '{"or_sext",    enc_r(6'h25, 5'd1, 5'd2, 5'd3), 16'h8000,  16'h0001,  32'hFFFF_8001};
    vecs[6]  = '{"slt_neg",    enc_r(6'h2A, 5'd1, 5'd2, 5'd3), 16'hFFFF,  16'd1,     32'h0000_0001};
    vecs[7]  = '{"slt_pos",    enc_r(6'h2A, 5'd1, 5'd2, 5'd3), 16'd1,     16'hFFFF,  32'h0000_0000};
    vecs[8]  = '{"slt_eq",     enc_r(6'h2A, 5'd1, 5'd2, 5'd3), 16'd5,     16'd5,     32'h0000_0000};
    vecs[9]  = '{"addi_neg",   enc_i(6'h08, 5'd1, 5'd3, 16'hFFFD), 16'd2, 16'd0,     32'hFFFF_FFFF};
    vecs[10] = '{"bad_funct",  enc_r(6'h21, 5'd1, 5'd2, 5'd3), 16'd5,     16'd7,     32'h0000_0000};
    vecs[11] = '{"bad_opcode", enc_i(6'h0D, 5'd1, 5'd3, 16'hFFFF), 16'd5, 16'd7,     32'h0000_0000};
    vecs[12] = '{"add_to_r0",  enc_r(6'h20, 5'd1, 5'd2, 5'd0), 16'd5,     16'd7,     32'h0000_0000};

    // Reset state
    tick(1);
    check("reset_pc", pc_out, 32'h0);
    check("reset_r1", dut.rf[1], 32'h0);
    check("reset_r31", dut.rf[31], 32'h0);
`ifndef IITK_MIPS_DEBUG_RESULT_EN
    check("debug_tied0", debug_result, 32'h0);
`endif

    // Build DMEM[0]=11, DMEM[1]=22 with a small program, then run the reference program
    prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd11), enc_i(6'h2B, 5'd0, 5'd1, 16'd0),
             enc_i(6'h08, 5'd0, 5'd1, 16'd22), enc_i(6'h2B, 5'd0, 5'd1, 16'd4),
             enc_j(26'd4)};
    start_prog();
    tick(6);
    check("pre_mem0", dut.DMEM.memory[0], 32'd11);
    check("pre_mem1", dut.DMEM.memory[1], 32'd22);

    prog = '{32'h8C08_0000, 32'h8C29_0004, 32'h0109_5020, 32'hAC4A_0008, 32'h0800_0004};
    start_prog();
    check("ref_pc0", pc_out, 32'h0);
    check("ref_instr0", instruction_out, 32'h8C08_0000);
    tick(2);
    check("ref_pc_add", pc_out, 32'h8);
`ifdef IITK_MIPS_DEBUG_RESULT_EN
    check("debug_add", debug_result, 32'd33);
`else
    check("debug_add", debug_result, 32'h0);
`endif
    tick(8);
    check("ref_mem2", dut.DMEM.memory[2], 32'd33);
    check("ref_r10", dut.rf[10], 32'd33);
    check("ref_pc_loop", pc_out, 32'h10);

    // Loader mode: core stalled, IMEM written, words visible at PC 0
    lw_words = '{enc_i(6'h2B, 5'd0, 5'd0, 16'd0), enc_i(6'h08, 5'd0, 5'd1, 16'd9),
                 enc_i(6'h08, 5'd0, 5'd2, 16'd3), enc_i(6'h2B, 5'd0, 5'd1, 16'd4),
                 enc_j(26'd4)};
    reset = 1'b1;
    init_mode = 1'b1;
    tick(1);
    reset = 1'b0;
    write_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      init_address = 12'(k);
      init_instruction = lw_words[k];
      tick(1);
      check("load_pc_hold", pc_out, 32'h0);
      check("load_ifetch", instruction_out, lw_words[0]);
    end
    check("load_no_dmem", dut.DMEM.memory[0], 32'd11);
    check("load_no_reg", dut.rf[1], 32'h0);
    // write_enable must be ignored once running
    init_address = 12'd4;
    init_instruction = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
    init_mode = 1'b0;
    tick(1);
    check("resume_pc", pc_out, 32'h4);
    check("resume_sw0", dut.DMEM.memory[0], 32'h0);
    tick(3);
    check("resume_pc_j", pc_out, 32'h10);
    tick(2);
    check("jself_pc", pc_out, 32'h10);
    check("we_ignored_r7", dut.rf[7], 32'h0);
    check("resume_mem1", dut.DMEM.memory[1], 32'd9);
    check("resume_r2", dut.rf[2], 32'd3);
    write_enable = 1'b0;

    // ALU / no-op vectors
    foreach (vecs[i]) begin
      prog = '{enc_i(6'h08, 5'd0, 5'd1, vecs[i].a), enc_i(6'h08, 5'd0, 5'd2, vecs[i].b),
               vecs[i].op3, enc_i(6'h2B, 5'd0, 5'd3, 16'h0100), enc_j(26'd4)};
      start_prog();
      tick(6);
      check({vecs[i].name, "_reg"}, dut.rf[3], vecs[i].exp);
      check({vecs[i].name, "_mem"}, dut.DMEM.memory[64], vecs[i].exp);
      check({vecs[i].name, "_pc"}, pc_out, 32'h10);
    end

    // Branches: beq taken skips one, bne with equal operands falls through
    prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'd5),
             enc_i(6'h04, 5'd1, 5'd2, 16'd1), enc_i(6'h08, 5'd0, 5'd3, 16'd1),
             enc_i(6'h05, 5'd1, 5'd2, 16'd1), enc_i(6'h08, 5'd0, 5'd4, 16'd1),
             enc_j(26'd6)};
    start_prog();
    tick(2);
    check("br_pc_beq", pc_out, 32'h8);
    tick(1);
    check("br_beq_taken", pc_out, 32'h10);
    tick(1);
    check("br_bne_not", pc_out, 32'h14);
    tick(3);
    check("br_pc_end", pc_out, 32'h18);
    check("br_skipped_r3", dut.rf[3], 32'h0);
    check("br_exec_r4", dut.rf[4], 32'd1);

    // $0 stays zero
    prog = '{enc_i(6'h08, 5'd0, 5'd5, 16'd99), enc_i(6'h2B, 5'd0, 5'd5, 16'd0),
             enc_i(6'h08, 5'd0, 5'd0, 16'd7), enc_i(6'h2B, 5'd0, 5'd0, 16'd0),
             enc_j(26'd4)};
    start_prog();
    tick(2);
    check("r0_mem_pre", dut.DMEM.memory[0], 32'd99);
    tick(3);
    check("r0_store", dut.DMEM.memory[0], 32'h0);

    // Pause mid-program, resume, then reset mid-program
    prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd3), enc_i(6'h08, 5'd0, 5'd2, 16'd4),
             enc_i(6'h2B, 5'd0, 5'd2, 16'd12), enc_i(6'h08, 5'd0, 5'd3, 16'd9),
             enc_j(26'd4)};
    start_prog();
    tick(2);
    check("mid_pc", pc_out, 32'h8);
    init_mode = 1'b1;
    write_enable = 1'b1;
    init_address = 12'd100;
    init_instruction = 32'h0;
    tick(3);
    check("pause_pc", pc_out, 32'h8);
    check("pause_r2", dut.rf[2], 32'd4);
    init_mode = 1'b0;
    write_enable = 1'b0;
    tick(1);
    check("unpause_pc", pc_out, 32'hC);
    check("unpause_mem3", dut.DMEM.memory[3], 32'd4);
    reset = 1'b1;
    init_mode = 1'bx;
    tick(1);
    check("rst_pc", pc_out, 32'h0);
    check("rst_r1", dut.rf[1], 32'h0);
    check("rst_r2", dut.rf[2], 32'h0);
    check("rst_mem3", dut.DMEM.memory[3], 32'd4);
    check("rst_instr0", instruction_out, prog[0]);
    reset = 1'b0;
    init_mode = 1'b0;
    tick(1);
    check("rst_rerun_pc", pc_out, 32'h4);
    check("rst_rerun_r1", dut.rf[1], 32'd3);

    // Address decoding: upper and low byte bits ignored, negative offsets
    prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'h1000), enc_i(6'h08, 5'd0, 5'd2, 16'd77),
             enc_i(6'h2B, 5'd1, 5'd2, 16'd8),    enc_i(6'h08, 5'd0, 5'd3, 16'd16),
             enc_i(6'h08, 5'd0, 5'd4, 16'd55),   enc_i(6'h2B, 5'd3, 5'd4, 16'hFFFC),
             enc_i(6'h2B, 5'd0, 5'd4, 16'h0022), enc_i(6'h23, 5'd0, 5'd5, 16'h1021),
             enc_j(26'd8)};
    start_prog();
    tick(12);
    check("addr_hi_ignored", dut.DMEM.memory[2], 32'd77);
    check("addr_neg_off", dut.DMEM.memory[3], 32'd55);
    check("addr_lo_ignored", dut.DMEM.memory[8], 32'd55);
    check("addr_lw_alias", dut.rf[5], 32'd55);
    check("addr_pc", pc_out, 32'h20);

    // Random straight-line programs vs an ISA-level model
    for (int it = 0; it < 8; it++) begin
      prog.delete();
      for (int k = 0; k < 8; k++) mr[k] = 32'h0;
      for (int k = 0; k < 16; k++) begin
        prog.push_back(enc_i(6'h2B, 5'd0, 5'd0, 16'(1024 + 4 * k)));
        mm[k] = 32'h0;
      end
      for (int n = 0; n < 24; n++) begin
        kind = $urandom_range(0, 8);
        s = $urandom_range(0, 7);
        t = $urandom_range(0, 7);
        d = $urandom_range(0, 7);
        w = $urandom_range(0, 15);
        imm = 16'($urandom);
        simm = {{16{imm[15]}}, imm};
        case (kind)
          0: begin
            prog.push_back(enc_i(6'h08, 5'(s), 5'(d), imm));
            if (d != 0) mr[d] = mr[s] + simm;
          end
          1: begin
            prog.push_back(enc_r(6'h20, 5'(s), 5'(t), 5'(d)));
            if (d != 0) mr[d] = mr[s] + mr[t];
          end
          2: begin
            prog.push_back(enc_r(6'h22, 5'(s), 5'(t), 5'(d)));
            if (d != 0) mr[d] = mr[s] - mr[t];
          end
          3: begin
            prog.push_back(enc_r(6'h24, 5'(s), 5'(t), 5'(d)));
            if (d != 0) mr[d] = mr[s] & mr[t];
          end
          4: begin
            prog.push_back(enc_r(6'h25, 5'(s), 5'(t), 5'(d)));
            if (d != 0) mr[d] = mr[s] | mr[t];
          end
          5: begin
            prog.push_back(enc_r(6'h2A, 5'(s), 5'(t), 5'(d)));
            if (d != 0) mr[d] = ($signed(mr[s]) < $signed(mr[t])) ? 32'd1 : 32'd0;
          end
          6: begin
            prog.push_back(enc_i(6'h2B, 5'd0, 5'(t), 16'(1024 + 4 * w)));
            mm[w] = mr[t];
          end
          7: begin
            prog.push_back(enc_i(6'h23, 5'd0, 5'(d), 16'(1024 + 4 * w)));
            if (d != 0) mr[d] = mm[w];
          end
          default: begin
            if (imm[0]) prog.push_back(enc_i(6'h0D, 5'(s), 5'(d), imm));
            else        prog.push_back(enc_r(6'h21, 5'(s), 5'(t), 5'(d)));
          end
        endcase
      end
      prog.push_back(enc_j(26'(prog.size())));
      start_prog();
      tick(prog.size() + 2);
      check("rnd_pc", pc_out, 32'(4 * (prog.size() - 1)));
      for (int r = 1; r < 8; r++) check("rnd_reg", dut.rf[r], mr[r]);
      for (int k = 0; k < 16; k++) check("rnd_mem", dut.DMEM.memory[256 + k], mm[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iitk_mini_mips.md
IITK_MINI_MIPS -- requirements
Module: iitk_mini_mips

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 4096: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 1024: data memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port init_mode, input, 1 bit: 1 = loader mode, core stalled.
REQ-006 SHALL have port write_enable, input, 1 bit: instruction-memory write strobe, honoured only in loader mode.
REQ-007 SHALL have port init_address, input, 12 bits: instruction-memory word index for loader writes.
REQ-008 SHALL have port init_instruction, input, 32 bits: instruction word to load.
REQ-009 SHALL have port pc_out, output, 32 bits: current byte PC.
REQ-010 SHALL have port instruction_out, output, 32 bits: instruction at the current PC (combinational read).
REQ-011 SHALL have port debug_result, output, 32 bits: current ALU result (see Configuration).
REQ-012 SHALL contain a data-memory instance named DMEM holding a word array named memory, indexed [0..DMEM_WORDS-1], so benches can preload and check it hierarchically.

Function
REQ-013 SHALL be a single-cycle MIPS32 subset: one instruction retires per clk when init_mode=0 and reset=0.
REQ-014 SHALL fetch from IMEM word index PC[13:2]; default next PC = PC+4, wrapping modulo 2^32.
REQ-015 SHALL implement R-type (opcode 0) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), writing rd.
REQ-016 SHALL implement addi 0x08 (sign-extended immediate, result to rt), lw 0x23, sw 0x2B; effective address = rs + sign-extended offset.
REQ-017 SHALL address DMEM word index = effective address[11:2]; low address bits 1:0 and bits above 11 ignored; word-aligned only.
REQ-018 SHALL implement beq 0x04 and bne 0x05: taken target = PC+4 + (sign-extended offset << 2).
REQ-019 SHALL implement j 0x02: next PC = {(PC+4)[31:28], target[25:0], 2'b00}; j to its own address is a legal infinite loop.
REQ-020 SHALL have 32x32-bit register file, two combinational reads, one write per clk; register 0 reads 0 and writes to it are discarded.
REQ-021 SHALL make lw data available combinationally within the same cycle; sw writes DMEM at the clock edge.
REQ-022 SHALL treat unsupported opcodes/functs as no-ops: no register or memory write, PC+4.
REQ-023 SHALL, while init_mode=1: hold PC, suppress register and DMEM writes, and write IMEM[init_address] <= init_instruction each clk where write_enable=1.
REQ-024 SHALL ignore write_enable when init_mode=0; resume execution from the held PC on the first clk after init_mode falls.
REQ-025 SHALL never be affected by X on init_mode during reset; reset has priority over init_mode.

Reset
REQ-026 SHALL, on a clk edge with reset=1, set PC=0 and clear all 32 registers to 0, including mid-program.
REQ-027 SHALL NOT clear IMEM or DMEM contents on reset (time-0 preloads survive reset).
REQ-028 SHALL present pc_out=0 the cycle after reset; instruction_out = IMEM[0].

Configuration
REQ-029 SHALL honour macro IITK_MIPS_DEBUG_RESULT_EN: defined -> debug_result = ALU result of the current instruction (address for lw/sw, sum for add); undefined -> debug_result tied to 32'h0 and no debug logic synthesized.

Verification
REQ-030 Preload DMEM.memory[0]=11, [1]=22; load 8C080000, 8C290004, 01095020, AC4A0008, 08000004 at 0..4; run 10 clk -> DMEM.memory[2]=33, pc_out stays 0x10.
REQ-031 Hold init_mode=1 for 5 clk with writes -> pc_out stays 0, no register/DMEM change; IMEM words read back via instruction_out at PC 0.
REQ-032 addi $1,$0,5; addi $2,$0,5; beq $1,$2,+1 -> skips next instruction; bne same operands -> not taken.
REQ-033 addi $0,$0,7 then sw $0,0($0) -> DMEM.memory[0]=0.
REQ-034 Assert reset after 3 executed instructions -> pc_out=0 next cycle, registers 0, DMEM contents unchanged.
REQ-035 With IITK_MIPS_DEBUG_RESULT_EN defined, add of 11+22 -> debug_result=33 that cycle; undefined -> debug_result=0 always.
